simon_control: RTL and testbench
================================

// Module: simon_control
// PURPOSE
//  Game-sequencing FSM for the Simon project: consumes the four status flags from the Simon datapath and drives its
//  control inputs (select, mode_leds, w_en). It decides when a pattern is stored, played back, checked against
//  the player's repeat, and when the game ends. Tracks the round number and the win/lose outcome for external display.
// PARAMETERS
//  ADDR_W      6    width of the datapath memory address / round counter
//  MAX_ROUNDS  63   number of stored patterns that constitutes a win (<= 2**ADDR_W - 1)
// PORTS
//  clk               in   1       clock; one game step per rising edge
//  rst               in   1       synchronous, active-high reset
//  is_legal          in   1       datapath: current switch pattern is a legal entry
//  play_gt_count     in   1       datapath: playback index has reached stored count (playback done)
//  repeat_eq_play    in   1       datapath: playback index > repeat index (repeat entries remain)
//  input_eq_pattern  in   1       datapath: switches equal memory word at read address
//  select            out  2       read-address mux select to datapath
//  mode_leds         out  3       mode code to datapath and mode LEDs
//  w_en              out  1       memory write enable to datapath
//  round             out  ADDR_W  number of patterns stored so far
//  won               out  1       sticky: MAX_ROUNDS completed
//  lost              out  1       sticky: repeat mismatch occurred
// BEHAVIOUR
//  State and mode encodings (one state per mode):
//   INPUT    mode_leds = 3'b001, select = 2'b00
//   PLAYBACK mode_leds = 3'b010, select = 2'b00
//   REPEAT   mode_leds = 3'b100, select = 2'b01
//   DONE     mode_leds = 3'b111, select = 2'b10
//  Output decoding:
//   - state is the only registered control; mode_leds and select are Moore-decoded from it.
//   - w_en is Mealy: w_en = (state==INPUT) && is_legal && !rst.
//  Reset: rst sampled high -> next cycle state=INPUT, round=0, won=0, lost=0.
//   - Outputs after reset: mode_leds=001, select=00; w_en follows is_legal.
//   - Reset mid-game (any state) aborts immediately with the same values.
//  Transitions, evaluated every clk edge with rst low:
//   - INPUT: is_legal=1 -> PLAYBACK, round<=round+1 (write occurs this same cycle). is_legal=0 -> stay, w_en=0.
//   - PLAYBACK: play_gt_count=1 -> REPEAT; else stay. Minimum one cycle in PLAYBACK.
//   - REPEAT, priority order:
//     1. input_eq_pattern=0 -> DONE, lost<=1.
//     2. Else repeat_eq_play=1 -> stay.
//     3. Else (last entry matched): round==MAX_ROUNDS -> DONE, won<=1; otherwise -> INPUT.
//   - DONE: absorbing until rst; the datapath replays memory under mode 111.
//  Boundary rules:
//   - won and lost are mutually exclusive; a mismatch on the final entry of round MAX_ROUNDS sets lost, not won.
//   - round saturates at MAX_ROUNDS; never wraps.
//   - Flags are ignored in states where they are not listed above.
//   - Illegal state encodings recover to INPUT on the next edge.
// STRUCTURE
//  Shared package simon_pkg, also used by the Simon datapath:
//   - state typedef and localparams.
//   - MODE_INPUT/PLAYBACK/REPEAT/DONE codes.
//   - SEL_PLAYBACK/REPEAT/DONE codes.
//  Single module, no sub-modules: the state register, round counter and won/lost flags fit in one always block
//  plus one combinational decode block.
// TESTING
//  - Reset: rst=1 for 2 cycles from DONE -> mode_leds=001, select=00, round=0, won=lost=0.
//  - Illegal input: is_legal=0 in INPUT for 5 cycles -> w_en=0, state stays INPUT, round=0.
//  - One round: is_legal=1 -> w_en=1 for 1 cycle, round=1, mode 010.
//    Then play_gt_count=1 -> mode 100. Then input_eq_pattern=1, repeat_eq_play=0 -> mode 001.
//  - Mismatch: in REPEAT, input_eq_pattern=0 together with repeat_eq_play=1 -> mode 111, select=10, lost=1, won=0.
//    Holds for 10 cycles.
//  - Win: MAX_ROUNDS=3, three correct rounds -> after 3rd REPEAT, mode 111, won=1, round=3.
//    A mismatch on that final entry instead gives lost=1, won=0.
//  - Mid-game reset: rst=1 during PLAYBACK with round=2 -> next cycle mode 001, round=0; no spurious w_en.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared encodings for the Simon controller and datapath: game states,
// mode codes presented on the LEDs, and read-address mux selects.
package simon_pkg;

  localparam int SIMON_ADDR_W     = 6;
  localparam int SIMON_MAX_ROUNDS = 63;

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [2:0] MODE_INPUT    = 3'b001;
  localparam logic [2:0] MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] MODE_REPEAT   = 3'b100;
  localparam logic [2:0] MODE_DONE     = 3'b111;

  localparam logic [1:0] SEL_PLAYBACK  = 2'b00;
  localparam logic [1:0] SEL_REPEAT    = 2'b01;
  localparam logic [1:0] SEL_DONE      = 2'b10;

endpackage

// File: rtl/simon_control.sv
// Simon game sequencer: stores a pattern, plays it back, checks the player's
// repeat, and tracks round count plus sticky win/lose outcome.
module simon_control
  import simon_pkg::*;
#(
  parameter int ADDR_W     = SIMON_ADDR_W,
  parameter int MAX_ROUNDS = SIMON_MAX_ROUNDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_legal,
  input  logic              play_gt_count,
  input  logic              repeat_eq_play,
  input  logic              input_eq_pattern,
  output logic [1:0]        select,
  output logic [2:0]        mode_leds,
  output logic              w_en,
  output logic [ADDR_W-1:0] round,
  output logic              won,
  output logic              lost
);

  localparam logic [ADDR_W-1:0] LAST_ROUND = ADDR_W'(MAX_ROUNDS);

  state_t state;
  state_t state_nx;
  logic   round_inc;
  logic   set_won;
  logic   set_lost;

  always_comb begin
    state_nx  = state;
    round_inc = 1'b0;
    set_won   = 1'b0;
    set_lost  = 1'b0;
    case (state)
      ST_INPUT: begin
        if (is_legal) begin
          state_nx  = ST_PLAYBACK;
          round_inc = 1'b1;
        end
      end
      ST_PLAYBACK: begin
        if (play_gt_count) state_nx = ST_PLAYBACK == ST_PLAYBACK ? ST_REPEAT : ST_REPEAT;
      end
      ST_REPEAT: begin
        // A mismatch always wins over the final-round check so won/lost stay exclusive.
        if (!input_eq_pattern) begin
          state_nx = ST_DONE;
          set_lost = 1'b1;
        end else if (!repeat_eq_play) begin
          if (round == LAST_ROUND) begin
            state_nx = ST_DONE;
            set_won  = 1'b1;
          end else begin
            state_nx = ST_INPUT;
          end
        end
      end
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_INPUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INPUT;
      round <= '0;
      won   <= 1'b0;
      lost  <= 1'b0;
    end else begin
      state <= state_nx;
      if (round_inc && (round != LAST_ROUND)) round <= round + 1'b1;
      if (set_won)  won  <= 1'b1;
      if (set_lost) lost <= 1'b1;
    end
  end

  always_comb begin
    mode_leds = MODE_INPUT;
    select    = SEL_PLAYBACK;
    case (state)
      ST_PLAYBACK: begin
        mode_leds = MODE_PLAYBACK;
        select    = SEL_PLAYBACK;
      end
      ST_REPEAT: begin
        mode_leds = MODE_REPEAT;
        select    = SEL_REPEAT;
      end
      ST_DONE: begin
        mode_leds = MODE_DONE;
        select    = SEL_DONE;
      end
      default: begin
        mode_leds = MODE_INPUT;
        select    = SEL_PLAYBACK;
      end
    endcase
  end

  // Write strobe is Mealy so the pattern lands in memory on the accepting edge.
  assign w_en = (state == ST_INPUT) && is_legal && !rst;

endmodule

// File: tb/tb_simon_control.sv
// Scenario bench for simon_control with a three-round game; expected output
// snapshots are queued as stimulus is applied and compared after each step.
module tb_simon_control;

  localparam int ADDR_W     = 6;
  localparam int MAX_ROUNDS = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              is_legal;
  logic              play_gt_count;
  logic              repeat_eq_play;
  logic              input_eq_pattern;
  logic [1:0]        select;
  logic [2:0]        mode_leds;
  logic              w_en;
  logic [ADDR_W-1:0] round;
  logic              won;
  logic              lost;

  int total = 0;
  int bad   = 0;

  logic [13:0] sb[$];
  logic [13:0] obs;

  assign obs = {mode_leds, select, w_en, round, won, lost};

  always #5 clk = ~clk;

  simon_control #(.ADDR_W(ADDR_W), .MAX_ROUNDS(MAX_ROUNDS)) dut (
    .clk              (clk),
    .rst              (rst),
    .is_legal         (is_legal),
    .play_gt_count    (play_gt_count),
    .repeat_eq_play   (repeat_eq_play),
    .input_eq_pattern (input_eq_pattern),
    .select           (select),
    .mode_leds        (mode_leds),
    .w_en             (w_en),
    .round            (round),
    .won              (won),
    .lost             (lost)
  );

  localparam logic [2:0] M_IN = 3'b001, M_PB = 3'b010, M_RP = 3'b100, M_DN = 3'b111;
  localparam logic [1:0] S_IN = 2'b00, S_RP = 2'b01, S_DN = 2'b10;

  function automatic logic [13:0] pk(logic [2:0] m, logic [1:0] s, logic w,
                                     logic [5:0] r, logic wn, logic ls);
    return {m, s, w, r, wn, ls};
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic l, logic p, logic r, logic i);
    is_legal = l; play_gt_count = p; repeat_eq_play = r; input_eq_pattern = i;
  endtask

  // Stimulus only: one full round, last entry matching or not.
  task automatic play_round(logic match_last);
    set_in(1, 0, 0, 0); edge_step();
    set_in(0, 1, 0, 0); edge_step();
    set_in(0, 0, 1, 1); edge_step();
    set_in(0, 0, 0, match_last); edge_step();
    set_in(0, 0, 0, 0); #1;
  endtask

  task automatic test_reset(string tag);
    logic [13:0] want;
    rst = 1'b1;
    set_in(1, 1, 1, 0);
    for (int c = 0; c < 2; c++) begin
      sb.push_back(pk(M_IN, S_IN, 1'b0, 6'd0, 1'b0, 1'b0));
      edge_step();
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL %s_hold%0d got=%b want=%b", tag, c, obs, want);
      end
    end
    rst = 1'b0;
    set_in(1, 0, 0, 0);
    #1;
    sb.push_back(pk(M_IN, S_IN, 1'b1, 6'd0, 1'b0, 1'b0));
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s_wen_follows got=%b want=%b", tag, obs, want);
    end
    set_in(0, 0, 0, 0);
    #1;
  endtask

  task automatic test_illegal();
    logic [13:0] want;
    set_in(0, 1, 1, 1);
    for (int c = 0; c < 5; c++) begin
      sb.push_back(pk(M_IN, S_IN, 1'b0, 6'd0, 1'b0, 1'b0));
      edge_step();
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL illegal_%0d got=%b want=%b", c, obs, want);
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_one_round();
    logic [13:0] want;
    logic [13:0] exp_list[6];
    set_in(1, 0, 0, 0);
    #1;
    sb.push_back(pk(M_IN, S_IN, 1'b1, 6'd0, 1'b0, 1'b0));
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL round_wen got=%b want=%b", obs, want);
    end
    exp_list[0] = pk(M_PB, S_IN, 1'b0, 6'd1, 1'b0, 1'b0);
    exp_list[1] = pk(M_PB, S_IN, 1'b0, 6'd1, 1'b0, 1'b0);
    exp_list[2] = pk(M_RP, S_RP, 1'b0, 6'd1, 1'b0, 1'b0);
    exp_list[3] = pk(M_RP, S_RP, 1'b0, 6'd1, 1'b0, 1'b0);
    exp_list[4] = pk(M_IN, S_IN, 1'b0, 6'd1, 1'b0, 1'b0);
    exp_list[5] = pk(M_IN, S_IN, 1'b0, 6'd1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: set_in(1, 0, 0, 0);
        1: set_in(0, 0, 1, 0);
        2: set_in(0, 1, 0, 0);
        3: set_in(1, 0, 1, 1);
        4: set_in(0, 0, 0, 1);
        default: set_in(0, 1, 0, 1);
      endcase
      sb.push_back(exp_list[c]);
      edge_step();
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL round_step%0d got=%b want=%b", c, obs, want);
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_mismatch();
    logic [13:0] want;
    set_in(1, 0, 0, 0); edge_step();
    set_in(0, 1, 0, 0); edge_step();
    set_in(0, 0, 1, 0);
    sb.push_back(pk(M_DN, S_DN, 1'b0, 6'd2, 1'b0, 1'b1));
    edge_step();
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL mismatch_enter got=%b want=%b", obs, want);
    end
    for (int c = 0; c < 10; c++) begin
      set_in(c[0], c[1], c[2], ~c[0]);
      sb.push_back(pk(M_DN, S_DN, 1'b0, 6'd2, 1'b0, 1'b1));
      edge_step();
      want = sb.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL mismatch_hold%0d got=%b want=%b", c, obs, want);
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_win();
    logic [13:0] want;
    play_round(1'b1);
    play_round(1'b1);
    sb.push_back(pk(M_IN, S_IN, 1'b0, 6'd2, 1'b0, 1'b0));
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL win_mid got=%b want=%b", obs, want);
    end
    play_round(1'b1);
    sb.push_back(pk(M_DN, S_DN, 1'b0, 6'd3, 1'b1, 1'b0));
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL win_final got=%b want=%b", obs, want);
    end
    test_reset("reset_after_win");
    play_round(1'b1);
    play_round(1'b1);
    play_round(1'b0);
    sb.push_back(pk(M_DN, S_DN, 1'b0, 6'd3, 1'b0, 1'b1));
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL lose_final got=%b want=%b", obs, want);
    end
  endtask

  task automatic test_mid_reset();
    logic [13:0] want;
    play_round(1'b1);
    set_in(1, 0, 0, 0);
    sb.push_back(pk(M_PB, S_IN, 1'b0, 6'd2, 1'b0, 1'b0));
    edge_step();
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL midrst_playback got=%b want=%b", obs, want);
    end
    rst = 1'b1;
    #1;
    sb.push_back(pk(M_PB, S_IN, 1'b0, 6'd2, 1'b0, 1'b0));
    sb.push_back(pk(M_IN, S_IN, 1'b0, 6'd0, 1'b0, 1'b0));
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL midrst_assert got=%b want=%b", obs, want);
    end
    edge_step();
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL midrst_after got=%b want=%b", obs, want);
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0);
    sb.push_back(pk(M_IN, S_IN, 1'b0, 6'd0, 1'b0, 1'b0));
    edge_step();
    want = sb.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL midrst_release got=%b want=%b", obs, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    test_reset("reset_init");
    test_illegal();
    test_one_round();
    test_mismatch();
    test_reset("reset_from_done");
    test_win();
    test_reset("reset_before_mid");
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
